// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes
// (RV32I load/store funct3), the responder FSM states and the data width.
package dmem_responder_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] SZ_B  = 3'd0;
   localparam logic [2:0] SZ_H  = 3'd1;
   localparam logic [2:0] SZ_W  = 3'd2;
   localparam logic [2:0] SZ_BU = 3'd4;
   localparam logic [2:0] SZ_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's load/store path and the
// data-memory responder. The core is the master, the responder the slave.
interface dmem_responder_if;
   import dmem_responder_pkg::*;

   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [31:0]       req_addr_i;
   logic [DATA_W-1:0] req_wdata_i;
   logic [2:0]        req_size_i;
   logic              rsp_valid_o;
   logic              rsp_ready_i;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

endinterface

// File: rtl/dmem_responder_mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: builds byte enables and
// replicated write data for stores, extracts and extends the addressed lane
// for loads, and flags illegal sizes and misaligned accesses.
module dmem_responder_mem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic              we,
   input  logic [2:0]        size,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rword,
   output logic [3:0]        be,
   output logic [DATA_W-1:0] wdata_sh,
   output logic [DATA_W-1:0] rdata,
   output logic              align_err
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Decode the access size into lane enables, load extension and alignment errors.
   always_comb begin
      be        = 4'b0000;
      wdata_sh  = '0;
      rdata     = '0;
      align_err = 1'b0;
      lane_b    = rword[{addr_lo, 3'b000} +: 8];
      lane_h    = addr_lo[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_B, SZ_BU: begin
            be       = 4'b0001 << addr_lo;
            wdata_sh = {4{wdata[7:0]}};
            rdata    = (size == SZ_B) ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            if (we && size == SZ_BU) align_err = 1'b1;
         end
         SZ_H, SZ_HU: begin
            be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_sh = {2{wdata[15:0]}};
            rdata    = (size == SZ_H) ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            if (addr_lo[0] || (we && size == SZ_HU)) align_err = 1'b1;
         end
         SZ_W: begin
            be       = 4'b1111;
            wdata_sh = wdata;
            rdata    = rword;
            if (addr_lo != 2'b00) align_err = 1'b1;
         end
         default: align_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits LATENCY
// cycles, then commits the store or captures the load result and holds the
// response until the consumer takes it.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 128,
   parameter int LATENCY     = 2
) (
   input logic              clk_i,
   input logic              rst_i,
   dmem_responder_if.slave  bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [29:0]      DEPTH_LIM = 30'(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_INIT  = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [2:0]        r_size;
   logic [DATA_W-1:0] mem [DEPTH_WORDS];
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              accept;
   logic              enter_resp;
   logic              cur_we;
   logic [31:0]       cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [2:0]        cur_size;
   logic [IDX_W-1:0]  idx;
   logic              range_err;
   logic              any_err;
   logic [3:0]        be;
   logic [DATA_W-1:0] wdata_sh;
   logic [DATA_W-1:0] ld_data;
   logic              align_err;

   assign accept     = bus.req_valid_i && (state == IDLE);
   assign enter_resp = (state != RESP) && (state_nx == RESP);

   assign cur_we    = (state == IDLE) ? bus.req_we_i    : r_we;
   assign cur_addr  = (state == IDLE) ? bus.req_addr_i  : r_addr;
   assign cur_wdata = (state == IDLE) ? bus.req_wdata_i : r_wdata;
   assign cur_size  = (state == IDLE) ? bus.req_size_i  : r_size;

   assign idx       = cur_addr[IDX_W+1:2];
   assign range_err = cur_addr[31:2] >= DEPTH_LIM;
   assign any_err   = range_err || align_err;

   assign bus.req_ready_o = (state == IDLE);
   assign bus.rsp_valid_o = (state == RESP);
   assign bus.rsp_rdata_o = rsp_rdata;
   assign bus.rsp_err_o   = rsp_err;

   dmem_responder_mem_lane_align u_mem_lane_align (
      .we        (cur_we),
      .size      (cur_size),
      .addr_lo   (cur_addr[1:0]),
      .wdata     (cur_wdata),
      .rword     (mem[idx]),
      .be        (be),
      .wdata_sh  (wdata_sh),
      .rdata     (ld_data),
      .align_err (align_err)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic: zero latency skips WAIT, the response is held until taken.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.req_valid_i) state_nx = (LATENCY == 0) ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_nx = RESP;
         RESP:    if (bus.rsp_ready_i) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Register the accepted request and count down the wait states.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= '0;
         cnt     <= '0;
      end else if (accept) begin
         r_we    <= bus.req_we_i;
         r_addr  <= bus.req_addr_i;
         r_wdata <= bus.req_wdata_i;
         r_size  <= bus.req_size_i;
         cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // On entry to RESP commit a legal store and capture the response word.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         for (int i = 0; i < DEPTH_WORDS; i++) mem[IDX_W'(i)] <= '0;
      end else if (enter_resp) begin
         rsp_err   <= any_err;
         rsp_rdata <= (any_err || cur_we) ? '0 : ld_data;
         if (!any_err && cur_we) begin
            for (int l = 0; l < 4; l++) begin
               if (be[l]) mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
            end
         end
      end
   end

endmodule
